// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the transmit framer and the future receiver.
//
// Contents:
//   parity_mode_t   - encoding of the 2-bit parity_mode input
//   tx_state_t      - transmit framer FSM states (exposed on the debug port)
//   DATA_W_MIN/MAX  - legal range of data bits per frame
//   CLK_DIV_MIN     - smallest legal clocks-per-bit divisor
//   parity_enabled  - true when a parity bit is appended to the frame
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11   // behaves exactly like PAR_NONE
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int DATA_W_MIN  = 5;
   localparam int DATA_W_MAX  = 9;
   localparam int CLK_DIV_MIN = 2;

   // Only the two defined parity modes produce a parity bit; the reserved
   // code falls through to "no parity".
   function automatic logic parity_enabled(input parity_mode_t mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period divisor. Counts 0..CLK_DIV-1 and wraps; tick marks the last
// cycle of each bit period. Shared between the transmit and receive paths.
//
// Parameters:
//   CLK_DIV  - clock cycles per bit period (>= 2)
// Ports:
//   clk      in  1  clock, rising edge
//   rst_n    in  1  asynchronous active-low reset
//   clr      in  1  synchronous clear; the count restarts from 0
//   tick     out 1  high for one cycle while the count equals CLK_DIV-1
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CNT_TOP);

   // Wrapping on tick means every new bit period starts at count 0, so a
   // state entered on tick is automatically aligned without an extra clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule : uart_baud_cnt

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer: one word per valid/ready handshake is serialised as
// start bit, DATA_W data bits LSB first, optional parity bit, 1 or 2 stop bits.
//
// Handshake: a word is accepted on a rising edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE; tx_valid is ignored in every other state.
// tx_data, parity_mode and stop2 are captured on accept and held for the
// whole frame, so the source may change them freely afterwards.
//
// Parameters:
//   DATA_W       - data bits per frame (5..9)
//   CLK_DIV      - clock cycles per bit period (>= 2)
// Ports:
//   clk          in  1       clock, rising edge
//   rst_n        in  1       asynchronous active-low reset
//   tx_data      in  DATA_W  word to send
//   tx_valid     in  1       source has a word
//   tx_ready     out 1       framer can accept (IDLE)
//   parity_mode  in  2       00 none, 01 even, 10 odd, 11 none
//   stop2        in  1       1 = two stop bits, 0 = one
//   tx           out 1       serial line, idle high, registered
//   busy         out 1       frame in progress
//   state_dbg    out 3       current FSM state (tx_state_t encoding)
// -----------------------------------------------------------------------------
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              tx,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   localparam int BCW = $clog2(DATA_W + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

   tx_state_t         state;
   logic [DATA_W-1:0] shift_q;
   logic [BCW-1:0]    bit_cnt;
   logic              par_en_q;
   logic              par_bit_q;
   logic              stop2_q;
   logic              stop_cnt;

   logic              tick;
   logic              baud_clr;
   logic              accept;
   parity_mode_t      mode_in;
   logic              par_bit_in;

   assign mode_in    = parity_mode_t'(parity_mode);
   assign accept     = tx_valid && tx_ready;
   // Even parity is the plain XOR of the data; odd parity is its inverse.
   assign par_bit_in = (^tx_data) ^ (mode_in == PAR_ODD);
   assign state_dbg  = state;

   // The divisor is held at 0 throughout IDLE so the START period begins at
   // count 0 on the accept edge; afterwards it wraps once per bit period.
   assign baud_clr = (state == IDLE);

   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .tick  (tick)
   );

   // Single-process FSM. tx, busy and tx_ready are all registered here, and
   // each transition loads tx with the value of the state being entered so
   // the line changes exactly on the bit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_q   <= '0;
         bit_cnt   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         stop_cnt  <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         tx_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
               if (accept) begin
                  shift_q   <= tx_data;
                  par_en_q  <= parity_enabled(mode_in);
                  par_bit_q <= par_bit_in;
                  stop2_q   <= stop2;
                  bit_cnt   <= '0;
                  stop_cnt  <= 1'b0;
                  state     <= START;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  tx_ready  <= 1'b0;
               end
            end

            START: begin
               if (tick) begin
                  state   <= DATA;
                  tx      <= shift_q[0];
                  bit_cnt <= '0;
               end
            end

            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        state <= PARITY;
                        tx    <= par_bit_q;
                     end else begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                     end
                  end else begin
                     // Bit 1 of the current register is the next bit on the
                     // line once the register has shifted right.
                     shift_q <= shift_q >> 1;
                     tx      <= shift_q[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            PARITY: begin
               if (tick) begin
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
               end
            end

            STOP: begin
               if (tick) begin
                  if (stop2_q && !stop_cnt) begin
                     stop_cnt <= 1'b1;
                  end else begin
                     stop_cnt <= 1'b0;
                     state    <= IDLE;
                     tx       <= 1'b1;
                     busy     <= 1'b0;
                     tx_ready <= 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
   import uart_pkg::*;

   localparam int CLK_DIV = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [7:0] data8;
   logic [6:0] data7;
   logic       valid8, valid7;
   logic [1:0] parity_mode;
   logic       stop2;
   logic       tx8, ready8, busy8;
   logic       tx7, ready7, busy7;
   logic [2:0] st8, st7;

   uart_tx_frame #(.DATA_W(8), .CLK_DIV(CLK_DIV)) dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_data     (data8),
      .tx_valid    (valid8),
      .tx_ready    (ready8),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx          (tx8),
      .busy        (busy8),
      .state_dbg   (st8)
   );

   uart_tx_frame #(.DATA_W(7), .CLK_DIV(CLK_DIV)) dut7 (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_data     (data7),
      .tx_valid    (valid7),
      .tx_ready    (ready7),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx          (tx7),
      .busy        (busy7),
      .state_dbg   (st7)
   );

   // Observed {tx, busy, tx_ready} of the DUT currently under test.
   logic       sel7;
   logic [2:0] obs;
   assign obs = sel7 ? {tx7, busy7, ready7} : {tx8, busy8, ready8};

   // ---------------- scoreboard ----------------
   logic [2:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // One bit period of frame: tx = b, busy = 1, tx_ready = 0.
   task automatic push_bit(input logic b);
      repeat (CLK_DIV) exp_q.push_back({b, 1'b1, 1'b0});
   endtask

   // Reference frame model, followed by the first idle cycle after the frame.
   task automatic push_frame(input logic [8:0] d, input int w, input logic [1:0] m, input logic s2);
      logic ones_odd;
      ones_odd = 1'b0;
      push_bit(1'b0);
      for (int i = 0; i < w; i++) begin
         push_bit(d[i]);
         ones_odd = ones_odd ^ d[i];
      end
      if (m == 2'b01) push_bit(ones_odd);
      else if (m == 2'b10) push_bit(~ones_odd);
      push_bit(1'b1);
      if (s2) push_bit(1'b1);
      exp_q.push_back(3'b101);
   endtask

   // ---------------- driver tasks ----------------
   // Presents a word at a falling edge, records the expected frame, and
   // returns 1 time unit after the accept edge (i.e. in frame cycle 1).
   task automatic start_frame(input string tag, input logic s7, input logic [8:0] d,
                              input logic [1:0] m, input logic s2, input logic hold);
      @(negedge clk);
      sel7        = s7;
      data8       = d[7:0];
      data7       = d[6:0];
      parity_mode = m;
      stop2       = s2;
      if (s7) valid7 = 1'b1;
      else    valid8 = 1'b1;
      #1;
      check({tag, "_idle"}, obs, 3'b101);
      push_frame(d, s7 ? 7 : 8, m, s2);
      @(posedge clk);
      #1;
      if (!hold) begin
         valid8 = 1'b0;
         valid7 = 1'b0;
      end
   endtask

   // Compares n consecutive cycles against the expected queue.
   task automatic drain(input string tag, input int n);
      logic [2:0] e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            check($sformatf("%s_qempty[%0d]", tag, i), obs, 3'bxxx);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), obs, e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input string tag, input logic s7, input logic [8:0] d,
                      input logic [1:0] m, input logic s2);
      start_frame(tag, s7, d, m, s2, 1'b0);
      drain(tag, exp_q.size());
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [8:0] rd;
      logic [1:0] rm;
      logic       rs;
      sel7        = 1'b0;
      data8       = '0;
      data7       = '0;
      valid8      = 1'b0;
      valid7      = 1'b0;
      parity_mode = 2'b00;
      stop2       = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check("reset_out8", {tx8, busy8, ready8}, 3'b101);
      check("reset_out7", {tx7, busy7, ready7}, 3'b101);
      check("reset_state8", st8, IDLE);
      check("reset_state7", st7, IDLE);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic frame and parity modes
      run("a5_even", 1'b0, 9'h0A5, 2'b01, 1'b0);
      run("a5_odd",  1'b0, 9'h0A5, 2'b10, 1'b0);
      run("01_even", 1'b0, 9'h001, 2'b01, 1'b0);
      run("7f_odd7", 1'b1, 9'h07F, 2'b10, 1'b0);
      run("7f_even7", 1'b1, 9'h07F, 2'b01, 1'b0);
      run("a5_none", 1'b0, 9'h0A5, 2'b00, 1'b0);

      // Two stop bits
      run("00_stop2", 1'b0, 9'h000, 2'b00, 1'b1);

      // Back-to-back with mid-frame input changes
      start_frame("b2b", 1'b0, 9'h055, 2'b01, 1'b0, 1'b1);
      data8       = 8'h3C;
      parity_mode = 2'b10;
      push_frame(9'h03C, 8, 2'b10, 1'b0);
      drain("b2b_first", 45);
      valid8 = 1'b0;
      drain("b2b_second", exp_q.size());

      // Reset during data bit 3 (frame cycles 17..20)
      start_frame("rst_mid", 1'b0, 9'h0A5, 2'b01, 1'b0, 1'b0);
      drain("rst_mid", 18);
      exp_q.delete();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_out", {tx8, busy8, ready8}, 3'b101);
      check("rst_mid_state", st8, IDLE);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      run("ff_after_rst", 1'b0, 9'h0FF, 2'b01, 1'b0);

      // Reserved parity mode matches "none" cycle for cycle
      run("81_rsvd", 1'b0, 9'h081, 2'b11, 1'b0);
      run("81_none", 1'b0, 9'h081, 2'b00, 1'b0);

      // Random frames on both widths
      for (int i = 0; i < 6; i++) begin
         rd = 9'($urandom_range(0, 255));
         rm = 2'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         run($sformatf("rand%0d", i), 1'(i % 2), rd, rm, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_uart_tx_frame
